// File: rtl/bist_scheduler.sv
// rtl/bist_scheduler.sv - round-robin scheduler sharing one BIST engine among requesters
module bist_scheduler #(
   parameter int NREQ      = 4,
   parameter int START_LEN = 2,
   parameter int TIMEOUT   = 20000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            result_clr,
   input  logic            eng_running,
   input  logic            eng_end,
   input  logic            sig_ok,
   output logic            eng_start,
   output logic [NREQ-1:0] grant,
   output logic [NREQ-1:0] ack,
   output logic [NREQ-1:0] result,
   output logic [NREQ-1:0] result_valid,
   output logic            timeout_err,
   output logic            busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, START, WAIT_RUN, WAIT_END, DONE} state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   ptr, ptr_nx, gidx, gidx_nx, pick;
   logic [PW:0]     sum, ptr_inc;
   logic [NREQ-1:0] mask, mask_nx, eligible, rot;
   logic [15:0]     wd, wd_nx;
   logic [7:0]      scnt, scnt_nx;
   logic            found;
   logic            eng_start_nx, terr_nx, busy_nx;
   logic [NREQ-1:0] grant_nx, ack_nx, result_nx, valid_nx;

   // Arbitration: first unmasked request at or above ptr, wrapping modulo NREQ
   always_comb begin
      eligible = req & ~mask;
      rot      = NREQ'({eligible, eligible} >> ptr);
      found    = 1'b0;
      pick     = '0;
      sum      = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
            pick  = sum[PW-1:0];
         end
      end
   end

   // Next state and next registered outputs; result_clr applies first so a capture overrides it
   always_comb begin
      state_nx     = state;
      ptr_nx       = ptr;
      gidx_nx      = gidx;
      mask_nx      = mask;
      wd_nx        = wd;
      scnt_nx      = scnt;
      eng_start_nx = eng_start;
      grant_nx     = grant;
      ack_nx       = '0;
      result_nx    = result;
      valid_nx     = result_valid;
      terr_nx      = timeout_err;
      ptr_inc      = {1'b0, gidx} + {{PW{1'b0}}, 1'b1};
      if (ptr_inc >= (PW+1)'(NREQ)) ptr_inc = '0;
      if (result_clr) begin
         result_nx = '0;
         valid_nx  = '0;
         terr_nx   = 1'b0;
      end
      case (state)
         IDLE: begin
            mask_nx = '0;
            if (found) begin
               gidx_nx        = pick;
               grant_nx       = '0;
               grant_nx[pick] = 1'b1;
               eng_start_nx   = 1'b1;
               scnt_nx        = '0;
               state_nx       = START;
            end
         end
         START: begin
            if (scnt == 8'(START_LEN - 1)) begin
               eng_start_nx = 1'b0;
               wd_nx        = '0;
               state_nx     = WAIT_RUN;
            end else begin
               scnt_nx = scnt + 8'd1;
            end
         end
         WAIT_RUN, WAIT_END: begin
            wd_nx = wd + 16'd1;
            if (wd == 16'(TIMEOUT - 1)) begin
               result_nx[gidx] = 1'b0;
               valid_nx[gidx]  = 1'b1;
               terr_nx         = 1'b1;
               ack_nx          = grant;
               state_nx        = DONE;
            end else if (state == WAIT_RUN) begin
               if (eng_running) state_nx = WAIT_END;
            end else if (!eng_running && eng_end) begin
               result_nx[gidx] = sig_ok;
               valid_nx[gidx]  = 1'b1;
               ack_nx          = grant;
               state_nx        = DONE;
            end
         end
         DONE: begin
            grant_nx = '0;
            mask_nx  = grant;
            ptr_nx   = ptr_inc[PW-1:0];
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   // State, counters and all outputs registered; reset abandons any run without ack
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         ptr          <= '0;
         gidx         <= '0;
         mask         <= '0;
         wd           <= '0;
         scnt         <= '0;
         eng_start    <= 1'b0;
         grant        <= '0;
         ack          <= '0;
         result       <= '0;
         result_valid <= '0;
         timeout_err  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nx;
         ptr          <= ptr_nx;
         gidx         <= gidx_nx;
         mask         <= mask_nx;
         wd           <= wd_nx;
         scnt         <= scnt_nx;
         eng_start    <= eng_start_nx;
         grant        <= grant_nx;
         ack          <= ack_nx;
         result       <= result_nx;
         result_valid <= valid_nx;
         timeout_err  <= terr_nx;
         busy         <= busy_nx;
      end
   end

endmodule

// File: tb/tb_bist_scheduler.sv
// tb/tb_bist_scheduler.sv - directed scoreboard bench for bist_scheduler
module tb_bist_scheduler;

   logic       clock, reset, result_clr, eng_running, eng_end, sig_ok;
   logic [3:0] req, grant, ack, result, result_valid;
   logic       eng_start, timeout_err, busy;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct { logic [3:0] ack; logic res; logic terr; } exp_t;
   exp_t sb[$];

   bist_scheduler dut (
      .clock(clock), .reset(reset), .req(req), .result_clr(result_clr),
      .eng_running(eng_running), .eng_end(eng_end), .sig_ok(sig_ok),
      .eng_start(eng_start), .grant(grant), .ack(ack), .result(result),
      .result_valid(result_valid), .timeout_err(timeout_err), .busy(busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic push(input logic [3:0] a, input logic r, input logic t);
      exp_t e;
      e.ack = a; e.res = r; e.terr = t;
      sb.push_back(e);
   endtask

   task automatic wait_grant(output logic [3:0] g);
      int n;
      tick();
      n = 1;
      while (grant === 4'b0 && n < 50) begin tick(); n++; end
      g = grant;
   endtask

   task automatic wait_start_end();
      int len;
      len = 0;
      while (eng_start === 1'b1 && len < 20) begin tick(); len++; end
      check("start_len", len, 2);
   endtask

   // Engine model: optional idle gap, run for n_run cycles, then end with sig_ok
   task automatic run_engine(input logic ok, input int gap, input int n_run,
                             input logic clr_at_end, input logic keep_end,
                             output logic [3:0] acked);
      int  cnt;
      logic early;
      wait_start_end();
      early = 1'b0;
      for (int i = 0; i < gap; i++) begin
         tick();
         if (ack !== 4'b0) early = 1'b1;
      end
      if (gap > 0) check("stale_end_no_ack", early, 0);
      eng_running = 1'b1;
      repeat (n_run) tick();
      eng_running = 1'b0;
      eng_end     = 1'b1;
      sig_ok      = ok;
      result_clr  = clr_at_end;
      cnt = 0;
      do begin tick(); cnt++; end while (ack === 4'b0 && cnt < 50);
      check("ack_seen", ack !== 4'b0, 1);
      acked      = ack;
      result_clr = 1'b0;
      sig_ok     = 1'b0;
      if (!keep_end) eng_end = 1'b0;
   endtask

   // Scoreboard side: every ack pops the oldest expectation
   always @(negedge clock) begin
      if (!reset && ack !== 4'b0) begin
         if (sb.size() == 0) begin
            check("unexpected_ack", ack, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("mon_ack", ack, e.ack);
            check("mon_result", |(result & e.ack), e.res);
            check("mon_valid", |(result_valid & e.ack), 1);
            check("mon_terr", timeout_err, e.terr);
         end
      end
   end

   initial begin
      logic [3:0] g, acked;
      int cnt;
      reset = 1'b1; req = '0; result_clr = 1'b0;
      eng_running = 1'b0; eng_end = 1'b0; sig_ok = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {eng_start, grant, ack, result, result_valid, timeout_err, busy}, 0);

      // single request
      reset = 1'b0;
      req = 4'b0001;
      wait_grant(g);
      check("single_grant", g, 4'b0001);
      check("single_busy", busy, 1);
      push(4'b0001, 1'b1, 1'b0);
      run_engine(1'b1, 0, 3, 1'b0, 1'b0, acked);
      req &= ~acked;
      tick();
      check("ack_one_cycle", ack, 0);
      check("busy_fall", busy, 0);
      check("single_result", {result, result_valid}, {4'b0001, 4'b0001});

      // round robin from ptr = 0
      reset = 1'b1;
      repeat (2) tick();
      check("reset_clears_results", {result, result_valid}, 0);
      reset = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         wait_grant(g);
         check("rr_grant", g, 4'b0001 << k);
         push(4'b0001 << k, (k % 2 == 0), 1'b0);
         run_engine((k % 2 == 0), 0, 2, 1'b0, 1'b0, acked);
         req &= ~acked;
      end
      tick();
      check("rr_results", {result, result_valid}, {4'b0101, 4'b1111});

      // failing run on requester 2, then fairness wrap
      req = 4'b0100;
      wait_grant(g);
      check("fail_grant", g, 4'b0100);
      push(4'b0100, 1'b0, 1'b0);
      run_engine(1'b0, 0, 2, 1'b0, 1'b0, acked);
      req = 4'b0101;
      tick();
      check("fail_capture", {result[2], result_valid[2]}, 2'b01);
      wait_grant(g);
      check("fair_wrap", g, 4'b0001);
      push(4'b0001, 1'b1, 1'b0);
      run_engine(1'b1, 0, 1, 1'b0, 1'b0, acked);
      req = 4'b0100;

      // held request is masked for one IDLE cycle after its DONE
      wait_grant(g);
      check("mask_first_grant", g, 4'b0100);
      push(4'b0100, 1'b1, 1'b0);
      run_engine(1'b1, 0, 1, 1'b0, 1'b0, acked);
      tick();
      check("mask_idle1", grant, 0);
      tick();
      check("mask_idle2", grant, 0);
      tick();
      check("mask_regrant", grant, 4'b0100);
      push(4'b0100, 1'b1, 1'b0);
      run_engine(1'b1, 0, 1, 1'b0, 1'b1, acked);
      req = 4'b0000;

      // stale eng_end must not complete; clear coincident with capture
      req = 4'b0001;
      wait_grant(g);
      check("stale_grant", g, 4'b0001);
      push(4'b0001, 1'b1, 1'b0);
      run_engine(1'b1, 5, 2, 1'b1, 1'b0, acked);
      req = 4'b0000;
      check("clr_coincide", {result, result_valid}, {4'b0001, 4'b0001});
      result_clr = 1'b1;
      tick();
      result_clr = 1'b0;
      check("clear_all", {result, result_valid, timeout_err}, 0);

      // mid-run reset aborts without ack, ptr returns to 0
      req = 4'b0001;
      wait_grant(g);
      check("abort_grant", g, 4'b0001);
      wait_start_end();
      eng_running = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("midrun_reset_outs", {eng_start, grant, ack, result, result_valid, timeout_err, busy}, 0);
      reset = 1'b0;
      eng_running = 1'b0;
      req = 4'b0011;
      wait_grant(g);
      check("post_reset_grant", g, 4'b0001);
      push(4'b0001, 1'b1, 1'b0);
      run_engine(1'b1, 0, 2, 1'b0, 1'b0, acked);
      req = 4'b0000;

      // watchdog timeout with the engine never running
      req = 4'b0100;
      wait_grant(g);
      check("timeout_grant", g, 4'b0100);
      push(4'b0100, 1'b0, 1'b1);
      wait_start_end();
      cnt = 0;
      do begin tick(); cnt++; end while (ack === 4'b0 && cnt < 25000);
      check("timeout_cycles", cnt, 20000);
      req = 4'b0000;
      tick();
      check("timeout_sticky", {timeout_err, result[2], result_valid[2]}, 3'b101);
      result_clr = 1'b1;
      tick();
      result_clr = 1'b0;
      check("timeout_clear", {result, result_valid, timeout_err}, 0);

      check("sb_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
